// File: rtl/fmul_72bit_arb_pkg.sv
// fmul_72bit_arb_pkg: shared width, data type and requester tag for the 72-bit multiplier issue arbiter
package fmul_72bit_arb_pkg;
    localparam int FMUL72_W = 72;
    typedef logic [FMUL72_W-1:0] fmul72_data_t;
    typedef enum logic {TAG_REQ0, TAG_REQ1} fmul72_tag_t;
endpackage

// File: rtl/fmul_72bit_arb_tag_fifo.sv
// fmul_72bit_arb_tag_fifo: in-order owner-tag FIFO for in-flight multiplier operations
module fmul_72bit_arb_tag_fifo
    import fmul_72bit_arb_pkg::*;
#(
    parameter int P_DEPTH = 8
) (
    input  logic                       iCLOCK,
    input  logic                       inRESET,
    input  logic                       iRESET_SYNC,
    input  logic                       iPUSH,
    input  fmul72_tag_t                iPUSH_TAG,
    input  logic                       iPOP,
    output fmul72_tag_t                oHEAD,
    output logic                       oEMPTY,
    output logic                       oFULL,
    output logic [$clog2(P_DEPTH):0]   oCOUNT
);
    localparam int LP_AW = $clog2(P_DEPTH);
    localparam logic [LP_AW:0] LP_FULL = (LP_AW+1)'(P_DEPTH);

    logic [LP_AW-1:0] r_wr_ptr;
    logic [LP_AW-1:0] r_rd_ptr;
    logic [LP_AW:0]   r_count;
    fmul72_tag_t      r_mem [P_DEPTH];

    // pointers wrap naturally because the depth is a power of two
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (iRESET_SYNC) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (iPUSH) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (iPOP) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (LP_AW+1)'(iPUSH) - (LP_AW+1)'(iPOP);
        end
    end

    // tag storage needs no reset; only entries below the count are ever read
    always_ff @(posedge iCLOCK) begin
        if (iPUSH) r_mem[r_wr_ptr] <= iPUSH_TAG;
    end

    assign oHEAD  = r_mem[r_rd_ptr];
    assign oEMPTY = r_count == '0;
    assign oFULL  = r_count == LP_FULL;
    assign oCOUNT = r_count;
endmodule

// File: rtl/fmul_72bit_issue_arbiter.sv
// fmul_72bit_issue_arbiter: two-requester issue arbiter and result steering for a shared 72-bit multiplier (FMUL72_ARB_FIXED_PRIORITY_EN selects fixed priority)
module fmul_72bit_issue_arbiter
    import fmul_72bit_arb_pkg::*;
#(
    parameter int P_DEPTH = 8
) (
    input  logic         iCLOCK,
    input  logic         inRESET,
    input  logic         iRESET_SYNC,
    input  logic         iREQ0_VALID,
    output logic         oREQ0_BUSY,
    input  fmul72_data_t iREQ0_DATA_A,
    input  fmul72_data_t iREQ0_DATA_B,
    input  logic         iREQ1_VALID,
    output logic         oREQ1_BUSY,
    input  fmul72_data_t iREQ1_DATA_A,
    input  fmul72_data_t iREQ1_DATA_B,
    output logic         oPIPE_VALID,
    input  logic         iPIPE_BUSY,
    output fmul72_data_t oPIPE_DATA_A,
    output fmul72_data_t oPIPE_DATA_B,
    input  logic         iPIPE_VALID,
    output logic         oPIPE_BUSY,
    input  fmul72_data_t iPIPE_DATA,
    output logic         oRES0_VALID,
    input  logic         iRES0_BUSY,
    output logic         oRES1_VALID,
    input  logic         iRES1_BUSY,
    output fmul72_data_t oRES0_DATA,
    output fmul72_data_t oRES1_DATA,
    output logic         oIDLE,
    output logic         oERROR
);
    logic                     r_pipe_valid;
    fmul72_data_t             r_pipe_a;
    fmul72_data_t             r_pipe_b;
    logic                     r_error;
    logic                     w_rst_act;
    logic                     w_load_en;
    logic                     w_ok;
    logic                     w_grant1;
    logic                     w_acc0;
    logic                     w_acc1;
    logic                     w_acc;
    fmul72_tag_t              w_acc_tag;
    fmul72_tag_t              w_head;
    logic                     w_empty;
    logic                     w_full;
    logic [$clog2(P_DEPTH):0] w_count;
    logic                     w_pop;

    assign w_rst_act = !inRESET || iRESET_SYNC;
    assign w_load_en = !r_pipe_valid || !iPIPE_BUSY;
    assign w_ok      = !w_rst_act && w_load_en && !w_full;

`ifdef FMUL72_ARB_FIXED_PRIORITY_EN
    assign w_grant1 = iREQ1_VALID && !iREQ0_VALID;
`else
    fmul72_tag_t r_rr_last;
    assign w_grant1 = iREQ1_VALID && (!iREQ0_VALID || r_rr_last == TAG_REQ0);

    // remember the last accepted requester so a tie goes to the other one
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) r_rr_last <= TAG_REQ1;
        else if (iRESET_SYNC) r_rr_last <= TAG_REQ1;
        else if (w_acc) r_rr_last <= w_acc_tag;
    end
`endif

    assign w_acc0     = iREQ0_VALID && !w_grant1 && w_ok;
    assign w_acc1     = w_grant1 && w_ok;
    assign w_acc      = w_acc0 || w_acc1;
    assign w_acc_tag  = w_acc1 ? TAG_REQ1 : TAG_REQ0;
    assign oREQ0_BUSY = !w_acc0;
    assign oREQ1_BUSY = !w_acc1;

    // issue register: load on accept, drain when the multiplier takes the operands
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_pipe_valid <= 1'b0;
            r_pipe_a     <= '0;
            r_pipe_b     <= '0;
        end else if (iRESET_SYNC) begin
            r_pipe_valid <= 1'b0;
            r_pipe_a     <= '0;
            r_pipe_b     <= '0;
        end else if (w_acc) begin
            r_pipe_valid <= 1'b1;
            r_pipe_a     <= w_acc1 ? iREQ1_DATA_A : iREQ0_DATA_A;
            r_pipe_b     <= w_acc1 ? iREQ1_DATA_B : iREQ0_DATA_B;
        end else if (w_load_en) begin
            r_pipe_valid <= 1'b0;
        end
    end

    fmul_72bit_arb_tag_fifo #(.P_DEPTH(P_DEPTH)) u_tag_fifo (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .iPUSH       (w_acc),
        .iPUSH_TAG   (w_acc_tag),
        .iPOP        (w_pop),
        .oHEAD       (w_head),
        .oEMPTY      (w_empty),
        .oFULL       (w_full),
        .oCOUNT      (w_count)
    );

    assign oRES0_VALID = iPIPE_VALID && !w_empty && w_head == TAG_REQ0;
    assign oRES1_VALID = iPIPE_VALID && !w_empty && w_head == TAG_REQ1;
    assign oRES0_DATA  = iPIPE_DATA;
    assign oRES1_DATA  = iPIPE_DATA;
    assign oPIPE_BUSY  = !w_empty && (w_head == TAG_REQ0 ? iRES0_BUSY : iRES1_BUSY);
    assign w_pop       = iPIPE_VALID && !w_empty && !oPIPE_BUSY;

    // sticky flag for a result that had no owner tag waiting
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) r_error <= 1'b0;
        else if (iRESET_SYNC) r_error <= 1'b0;
        else if (iPIPE_VALID && w_empty) r_error <= 1'b1;
    end

    assign oPIPE_VALID  = r_pipe_valid;
    assign oPIPE_DATA_A = r_pipe_a;
    assign oPIPE_DATA_B = r_pipe_b;
    assign oIDLE        = w_count == '0 && !r_pipe_valid;
    assign oERROR       = r_error;
endmodule

// File: tb/tb_fmul_72bit_issue_arbiter.sv
// tb_fmul_72bit_issue_arbiter: directed and randomized checks against a queue-based reference model
module tb_fmul_72bit_issue_arbiter;
    localparam int DEPTH = 8;
`ifdef FMUL72_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        iCLOCK = 1'b0;
    logic        inRESET, iRESET_SYNC;
    logic        iREQ0_VALID, iREQ1_VALID, iPIPE_BUSY, iPIPE_VALID, iRES0_BUSY, iRES1_BUSY;
    logic [71:0] iREQ0_DATA_A, iREQ0_DATA_B, iREQ1_DATA_A, iREQ1_DATA_B, iPIPE_DATA;
    logic        oREQ0_BUSY, oREQ1_BUSY, oPIPE_VALID, oPIPE_BUSY, oRES0_VALID, oRES1_VALID, oIDLE, oERROR;
    logic [71:0] oPIPE_DATA_A, oPIPE_DATA_B, oRES0_DATA, oRES1_DATA;

    int n_cmp = 0;
    int n_err = 0;

    int          m_q[$];
    bit          m_pv;
    logic [71:0] m_a, m_b;
    int          m_last;
    bit          m_err;

    always #5 iCLOCK = ~iCLOCK;

    fmul_72bit_issue_arbiter #(.P_DEPTH(DEPTH)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
        .iREQ0_VALID(iREQ0_VALID), .oREQ0_BUSY(oREQ0_BUSY), .iREQ0_DATA_A(iREQ0_DATA_A), .iREQ0_DATA_B(iREQ0_DATA_B),
        .iREQ1_VALID(iREQ1_VALID), .oREQ1_BUSY(oREQ1_BUSY), .iREQ1_DATA_A(iREQ1_DATA_A), .iREQ1_DATA_B(iREQ1_DATA_B),
        .oPIPE_VALID(oPIPE_VALID), .iPIPE_BUSY(iPIPE_BUSY), .oPIPE_DATA_A(oPIPE_DATA_A), .oPIPE_DATA_B(oPIPE_DATA_B),
        .iPIPE_VALID(iPIPE_VALID), .oPIPE_BUSY(oPIPE_BUSY), .iPIPE_DATA(iPIPE_DATA),
        .oRES0_VALID(oRES0_VALID), .iRES0_BUSY(iRES0_BUSY), .oRES1_VALID(oRES1_VALID), .iRES1_BUSY(iRES1_BUSY),
        .oRES0_DATA(oRES0_DATA), .oRES1_DATA(oRES1_DATA), .oIDLE(oIDLE), .oERROR(oERROR)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_q.delete();
        m_pv   = 1'b0;
        m_a    = '0;
        m_b    = '0;
        m_last = 1;
        m_err  = 1'b0;
    endtask

    // one clock: check every output against the model at the falling edge, then advance the model
    task automatic tick();
        bit rst_act, load, credit, ok, emp, pbusy;
        int win, head;
        @(negedge iCLOCK);
        if (!inRESET) mreset();
        rst_act = !inRESET || iRESET_SYNC;
        load    = !m_pv || !iPIPE_BUSY;
        credit  = m_q.size() < DEPTH;
        ok      = !rst_act && load && credit;
        win     = -1;
        if (iREQ0_VALID && iREQ1_VALID) win = FIXED ? 0 : 1 - m_last;
        else if (iREQ0_VALID) win = 0;
        else if (iREQ1_VALID) win = 1;
        emp   = m_q.size() == 0;
        head  = emp ? 0 : m_q[0];
        pbusy = !emp && (head == 0 ? iRES0_BUSY : iRES1_BUSY);
        chk("req0_busy", oREQ0_BUSY, !(win == 0 && ok));
        chk("req1_busy", oREQ1_BUSY, !(win == 1 && ok));
        chk("pipe_busy", oPIPE_BUSY, pbusy);
        chk("res0_valid", oRES0_VALID, iPIPE_VALID && !emp && head == 0);
        chk("res1_valid", oRES1_VALID, iPIPE_VALID && !emp && head == 1);
        chk("res0_data", oRES0_DATA, iPIPE_DATA);
        chk("res1_data", oRES1_DATA, iPIPE_DATA);
        chk("pipe_valid", oPIPE_VALID, m_pv);
        chk("pipe_a", oPIPE_DATA_A, m_a);
        chk("pipe_b", oPIPE_DATA_B, m_b);
        chk("idle", oIDLE, emp && !m_pv);
        chk("error", oERROR, m_err);
        @(posedge iCLOCK);
        if (rst_act) mreset();
        else begin
            if (iPIPE_VALID && emp) m_err = 1'b1;
            if (iPIPE_VALID && !emp && !pbusy) void'(m_q.pop_front());
            if (win >= 0 && ok) begin
                m_q.push_back(win);
                m_pv   = 1'b1;
                m_a    = win == 1 ? iREQ1_DATA_A : iREQ0_DATA_A;
                m_b    = win == 1 ? iREQ1_DATA_B : iREQ0_DATA_B;
                m_last = win;
            end else if (load) m_pv = 1'b0;
        end
        #1;
    endtask

    task automatic rst_pulse();
        inRESET = 1'b0;
        tick();
        inRESET = 1'b1;
    endtask

    task automatic drain(input int n);
        iPIPE_VALID = 1'b1;
        repeat (n) tick();
        iPIPE_VALID = 1'b0;
    endtask

    initial begin
        logic [95:0] r0, r1, r2, r3, r4;
        int rec;
        inRESET = 1'b0; iRESET_SYNC = 1'b0;
        iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0; iPIPE_BUSY = 1'b0; iPIPE_VALID = 1'b0;
        iRES0_BUSY = 1'b0; iRES1_BUSY = 1'b0;
        iREQ0_DATA_A = '0; iREQ0_DATA_B = '0; iREQ1_DATA_A = '0; iREQ1_DATA_B = '0; iPIPE_DATA = '0;
        mreset();
        #1;
        tick();
        chk("rst_idle", oIDLE, 1'b1);
        chk("rst_busy0", oREQ0_BUSY, 1'b1);
        tick();
        inRESET = 1'b1;

        // single request from requester 0 and its result
        iREQ0_VALID = 1'b1; iREQ0_DATA_A = 72'h1; iREQ0_DATA_B = 72'h2;
        tick();
        iREQ0_VALID = 1'b0;
        chk("t1_pv", oPIPE_VALID, 1'b1);
        chk("t1_a", oPIPE_DATA_A, 72'h1);
        chk("t1_b", oPIPE_DATA_B, 72'h2);
        iPIPE_VALID = 1'b1; iPIPE_DATA = 72'hAB;
        #1;
        chk("t1_r0v", oRES0_VALID, 1'b1);
        chk("t1_r0d", oRES0_DATA, 72'hAB);
        chk("t1_r1v", oRES1_VALID, 1'b0);
        tick();
        iPIPE_VALID = 1'b0;
        tick();

        // tie-break sequence from reset
        rst_pulse();
        iREQ0_VALID = 1'b1; iREQ1_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            rec = !oREQ0_BUSY ? 0 : (!oREQ1_BUSY ? 1 : 2);
            chk($sformatf("tie_seq%0d", i), rec, FIXED ? 0 : i % 2);
            tick();
        end
        iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0;
        drain(4);

        // credit exhaustion and release of exactly one credit
        rst_pulse();
        iREQ0_VALID = 1'b1;
        repeat (DEPTH) tick();
        iREQ1_VALID = 1'b1;
        #1;
        chk("full_busy0", oREQ0_BUSY, 1'b1);
        chk("full_busy1", oREQ1_BUSY, 1'b1);
        tick();
        iPIPE_VALID = 1'b1;
        tick();
        iPIPE_VALID = 1'b0;
        #1;
        chk("one_credit", 72'(!oREQ0_BUSY) + 72'(!oREQ1_BUSY), 72'd1);
        tick();
        chk("refull_busy0", oREQ0_BUSY, 1'b1);
        chk("refull_busy1", oREQ1_BUSY, 1'b1);
        iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0;
        drain(DEPTH);

        // owner backpressure holds results in order
        rst_pulse();
        iREQ0_VALID = 1'b1;
        tick();
        iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b1;
        tick();
        iREQ1_VALID = 1'b0;
        iPIPE_VALID = 1'b1; iRES0_BUSY = 1'b1; iPIPE_DATA = 72'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_pbusy%0d", i), oPIPE_BUSY, 1'b1);
            chk($sformatf("bp_r1v%0d", i), oRES1_VALID, 1'b0);
            tick();
        end
        iRES0_BUSY = 1'b0;
        #1;
        chk("bp_rel_r0v", oRES0_VALID, 1'b1);
        tick();
        chk("bp_rel_r1v", oRES1_VALID, 1'b1);
        tick();
        iPIPE_VALID = 1'b0;

        // issue stall keeps operands stable
        rst_pulse();
        iREQ0_VALID = 1'b1; iREQ0_DATA_A = 72'h5; iREQ0_DATA_B = 72'h6;
        tick();
        iPIPE_BUSY = 1'b1; iREQ0_DATA_A = 72'h7; iREQ0_DATA_B = 72'h8;
        iREQ1_VALID = 1'b1; iREQ1_DATA_A = 72'h9; iREQ1_DATA_B = 72'hA;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("st_a%0d", i), oPIPE_DATA_A, 72'h5);
            chk($sformatf("st_b%0d", i), oPIPE_DATA_B, 72'h6);
            chk($sformatf("st_busy%0d", i), 72'({oREQ0_BUSY, oREQ1_BUSY}), 72'h3);
            tick();
        end
        iPIPE_BUSY = 1'b0;
        tick();
        iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0;
        chk("st_rel_a", oPIPE_DATA_A, FIXED ? 72'h7 : 72'h9);
        tick();
        drain(2);

        // result with no owner sets a sticky error
        chk("err_before", oERROR, 1'b0);
        iPIPE_VALID = 1'b1;
        #1;
        chk("err_pbusy", oPIPE_BUSY, 1'b0);
        tick();
        iPIPE_VALID = 1'b0;
        chk("err_set", oERROR, 1'b1);
        repeat (3) tick();
        chk("err_sticky", oERROR, 1'b1);

        // asynchronous reset with operations in flight
        iREQ0_VALID = 1'b1;
        repeat (3) tick();
        chk("mid_not_idle", oIDLE, 1'b0);
        inRESET = 1'b0;
        #1;
        chk("ar_pv", oPIPE_VALID, 1'b0);
        chk("ar_a", oPIPE_DATA_A, 72'h0);
        chk("ar_err", oERROR, 1'b0);
        chk("ar_idle", oIDLE, 1'b1);
        chk("ar_busy0", oREQ0_BUSY, 1'b1);
        tick();
        inRESET = 1'b1; iREQ0_VALID = 1'b0;
        tick();
        chk("ar_idle_after", oIDLE, 1'b1);

        // synchronous clear
        iREQ1_VALID = 1'b1;
        repeat (2) tick();
        iREQ1_VALID = 1'b0; iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        chk("sr_idle", oIDLE, 1'b1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r0 = {$urandom, $urandom, $urandom}; r1 = {$urandom, $urandom, $urandom};
            r2 = {$urandom, $urandom, $urandom}; r3 = {$urandom, $urandom, $urandom};
            r4 = {$urandom, $urandom, $urandom};
            iREQ0_DATA_A = r0[71:0]; iREQ0_DATA_B = r1[71:0];
            iREQ1_DATA_A = r2[71:0]; iREQ1_DATA_B = r3[71:0]; iPIPE_DATA = r4[71:0];
            iREQ0_VALID = $urandom_range(0, 99) < 60;
            iREQ1_VALID = $urandom_range(0, 99) < 60;
            iPIPE_BUSY  = $urandom_range(0, 99) < 25;
            iPIPE_VALID = $urandom_range(0, 99) < 50;
            iRES0_BUSY  = $urandom_range(0, 99) < 30;
            iRES1_BUSY  = $urandom_range(0, 99) < 30;
            iRESET_SYNC = $urandom_range(0, 199) == 0;
            inRESET     = $urandom_range(0, 299) != 0;
            tick();
        end
        inRESET = 1'b1; iRESET_SYNC = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fmul_72bit_issue_arbiter.md
# fmul_72bit_issue_arbiter

Shares one 72-bit floating multiplier pipeline between two requesters. Round-robin arbitration selects the requester, which is issued through a registered issue stage. A tag FIFO records which requester owns each in-flight operation. Returning results are steered back to their owner in order, with backpressure propagated into the multiplier pipeline's global stall.

## Interface
- P_DEPTH, 8, maximum in-flight operations (power of two, ≥2); also the tag FIFO depth
- iCLOCK  in  1  clock
- inRESET  in  1  asynchronous active-low reset
- iRESET_SYNC  in  1  synchronous clear, same effect as inRESET
- iREQ0_VALID / oREQ0_BUSY  in/out  1  requester 0 handshake
- iREQ0_DATA_A, iREQ0_DATA_B  in  72  requester 0 operands
- iREQ1_VALID / oREQ1_BUSY  in/out  1  requester 1 handshake
- iREQ1_DATA_A, iREQ1_DATA_B  in  72  requester 1 operands
- oPIPE_VALID / iPIPE_BUSY  out/in  1  issue handshake to the multiplier
- oPIPE_DATA_A, oPIPE_DATA_B  out  72  issued operands
- iPIPE_VALID / oPIPE_BUSY  in/out  1  result handshake from the multiplier; oPIPE_BUSY drives its stall input
- iPIPE_DATA  in  72  result
- oRES0_VALID / iRES0_BUSY  out/in  1  result handshake to requester 0
- oRES1_VALID / iRES1_BUSY  out/in  1  result handshake to requester 1
- oRES0_DATA, oRES1_DATA  out  72  result data
- oIDLE  out  1  no in-flight operations and the issue register is empty
- oERROR  out  1  sticky: a result arrived while the tag FIFO was empty

## Operation
- A transfer on any valid/busy pair occurs when VALID=1 and BUSY=0 in the same cycle.
- load_en = !oPIPE_VALID || !iPIPE_BUSY. credit_ok = inflight < P_DEPTH.
- Grant is combinational:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester other than rr_last is granted.
  - oREQn_BUSY = !(grant==n && load_en && credit_ok). It is 1 for a requester that is not valid.
- On a requester accept:
  - The operands load into the issue register and oPIPE_VALID is set.
  - The tag n is pushed into the FIFO, inflight increments, and rr_last becomes n.
- If load_en is true and no accept occurs, oPIPE_VALID clears.
- Result steering uses head = FIFO head tag:
  - oRESn_VALID = iPIPE_VALID && !empty && head==n.
  - oRESn_DATA = iPIPE_DATA for both n.
  - oPIPE_BUSY = !empty && (head==0 ? iRES0_BUSY : iRES1_BUSY). It is 0 when the FIFO is empty.
- A result delivery pops the FIFO and decrements inflight.
- A simultaneous accept and delivery leaves inflight unchanged. The FIFO pointers wrap modulo P_DEPTH.
- If iPIPE_VALID=1 while the FIFO is empty, the result is dropped (oPIPE_BUSY=0) and oERROR sets. oERROR clears only by reset.
- inflight is $clog2(P_DEPTH)+1 bits wide and never exceeds P_DEPTH. When inflight==P_DEPTH, both oREQn_BUSY are 1.
- oIDLE = (inflight==0) && !oPIPE_VALID.

## Timing
- Reset or iRESET_SYNC values:
  - oPIPE_VALID=0, oPIPE_DATA_A/B=0.
  - inflight=0, FIFO empty, rr_last=1 (requester 0 wins the first tie).
  - oERROR=0, oIDLE=1.
  - oREQn_BUSY=1 while reset is asserted.
- Issue latency is 1 cycle: an accept at edge t gives oPIPE_VALID=1 in cycle t+1.
- While iPIPE_BUSY=1, oPIPE_VALID and oPIPE_DATA hold stable.
- Result path latency is 0 cycles (combinational pass-through). oPIPE_BUSY follows the owner's busy in the same cycle.
- A reset in mid-operation discards all in-flight tags. The system must also clear the multiplier via iRESET_SYNC in the same cycle.

## Configuration
- FMUL72_ARB_FIXED_PRIORITY_EN
  - Defined: requester 0 always wins when both are valid, and rr_last is not implemented.
  - Undefined: round-robin as above.
  - Tag tracking, credits and steering are identical in both builds.

## Structure
- Package fmul_72bit_arb_pkg holds:
  - localparam FMUL72_W=72.
  - typedef logic [71:0] fmul72_data_t.
  - typedef enum logic {TAG_REQ0, TAG_REQ1} fmul72_tag_t.
- Sub-module fmul_72bit_arb_tag_fifo:
  - Parameterised by P_DEPTH; 1-bit tag.
  - Ports: push, pop, head, empty, full, count.
  - Same async reset and iRESET_SYNC clear.
- Arbiter, issue register, credit logic and steering stay in the top module.

## Test plan
- Only REQ0 is valid with A=72'h1, B=72'h2 and no stall. oPIPE_VALID=1 the next cycle with those operands. A result with iPIPE_DATA=72'hAB appears on oRES0_VALID/oRES0_DATA, and oRES1_VALID stays 0.
- Both requesters are continuously valid, no stall. The sequence of issued tags from reset is 0,1,0,1. With FMUL72_ARB_FIXED_PRIORITY_EN defined it is 0,0,0,0.
- Issue 8 operations with P_DEPTH=8 and return no results. Both oREQn_BUSY are 1. One result delivered frees exactly one credit and one new accept follows.
- Results are tagged 0,1. Hold iRES0_BUSY=1 for 3 cycles. oPIPE_BUSY=1 for those 3 cycles, the REQ1 result is not delivered early, and ordering is preserved after release.
- Hold iPIPE_BUSY=1 while oPIPE_VALID=1. The issue operands stay stable and both oREQn_BUSY are 1 until release.
- Pulse iPIPE_VALID with the FIFO empty. oERROR=1 and stays 1. Pulse inRESET low with 3 operations in flight. All outputs return to reset values and oIDLE=1.
